// File: rtl/usb_serial_in_ep_buf.sv
// usb_serial_in_ep_buf
// Bulk IN endpoint buffer. A show-ahead byte FIFO sits between a byte-stream
// producer and one IN-endpoint slot of the protocol engine. The buffer cuts the
// FIFO contents into packets of up to MAX_PKT bytes. A partial packet is sent
// when it has waited FLUSH_FRAMES SOFs or when flush is pulsed. When ZLP_EN is
// set, a zero-length packet follows a full-size packet that emptied the FIFO.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   usb_reset             bus reset from the protocol engine; aborts the packet
//   sof_valid             one-cycle pulse per received SOF
//   uart_in_*             producer byte stream (valid/ready)
//   flush                 pulse: send pending bytes without waiting for SOFs
//   in_ep_*               PE IN-endpoint buffer handshake and data
//   fifo_level            bytes currently buffered
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | collecting bytes, waiting for a send condition
// REQ      | requesting the PE buffer, waiting for grant
// FILL     | writing pkt_len bytes into the PE buffer
// DONE     | one-cycle packet-complete strobe
// WAIT_ACK | packet handed off, waiting for the host ACK
module usb_serial_in_ep_buf #(
    parameter int DEPTH        = 64,
    parameter int MAX_PKT      = 64,
    parameter int FLUSH_FRAMES = 2,
    parameter bit ZLP_EN       = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       usb_reset,
    input  logic                       sof_valid,
    input  logic [7:0]                 uart_in_data,
    input  logic                       uart_in_valid,
    output logic                       uart_in_ready,
    input  logic                       flush,
    output logic                       in_ep_req,
    input  logic                       in_ep_grant,
    input  logic                       in_ep_data_free,
    output logic                       in_ep_data_put,
    output logic [7:0]                 in_ep_data,
    output logic                       in_ep_data_done,
    output logic                       in_ep_stall,
    input  logic                       in_ep_acked,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(MAX_PKT) + 1;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        FILL     = 3'd2,
        DONE     = 3'd3,
        WAIT_ACK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   pkt_len_q, pkt_len_d;
    logic [PW-1:0]   sent_q, sent_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zlp_q, zlp_d;
    logic            flushp_q, flushp_d;

    logic            push, pop, level_nz, data_trig, enter_req;
    logic [PW-1:0]   pkt_min;

    assign level_nz      = (level_q != '0);
    assign uart_in_ready = (level_q != LW'(DEPTH));
    assign push          = uart_in_valid & uart_in_ready;
    assign pop           = in_ep_data_put;
    assign in_ep_data    = mem_q[rd_ptr_q];
    assign in_ep_stall   = 1'b0;
    assign fifo_level    = level_q;

    assign pkt_min = (level_q >= LW'(MAX_PKT)) ? PW'(MAX_PKT) : level_q[PW-1:0];

    // A flush pulse counts immediately so the request goes out on the next cycle.
    assign data_trig = (level_q >= LW'(MAX_PKT))
                     | (level_nz & (cnt_q == CW'(FLUSH_FRAMES)))
                     | (level_nz & (flushp_q | flush));

    always_comb begin
        state_d         = state_q;
        pkt_len_d       = pkt_len_q;
        sent_d          = sent_q;
        zlp_d           = zlp_q;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_trig || zlp_q) begin
                    state_d   = REQ;
                    pkt_len_d = data_trig ? pkt_min : '0;
                    sent_d    = '0;
                end
            end
            REQ: begin
                in_ep_req = 1'b1;
                if (in_ep_grant) state_d = FILL;
            end
            FILL: begin
                in_ep_req = 1'b1;
                if (sent_q == pkt_len_q) begin
                    state_d = DONE;
                end else if (in_ep_grant && in_ep_data_free) begin
                    in_ep_data_put = 1'b1;
                    sent_d         = sent_q + PW'(1);
                end
            end
            DONE: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                state_d         = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (in_ep_acked) begin
                    state_d = IDLE;
                    zlp_d   = ZLP_EN && (pkt_len_q == PW'(MAX_PKT)) && !level_nz;
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus reset aborts the packet; bytes already popped are lost.
        if (usb_reset) begin
            state_d         = IDLE;
            zlp_d           = 1'b0;
            in_ep_req       = 1'b0;
            in_ep_data_put  = 1'b0;
            in_ep_data_done = 1'b0;
        end
    end

    assign enter_req = (state_q == IDLE) && (state_d == REQ);

    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);

        cnt_d = cnt_q;
        if (usb_reset || ((state_d == IDLE) && (state_q != IDLE)) || (push && !level_nz)) begin
            cnt_d = '0;
        end else if ((state_q == IDLE) && sof_valid && level_nz
                     && (cnt_q != CW'(FLUSH_FRAMES))) begin
            cnt_d = cnt_q + CW'(1);
        end

        flushp_d = flushp_q;
        if (enter_req) begin
            flushp_d = 1'b0;
        end else if (flush && level_nz) begin
            flushp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_len_q <= '0;
            sent_q    <= '0;
            cnt_q     <= '0;
            zlp_q     <= 1'b0;
            flushp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pkt_len_q <= pkt_len_d;
            sent_q    <= sent_d;
            cnt_q     <= cnt_d;
            zlp_q     <= zlp_d;
            flushp_q  <= flushp_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= uart_in_data;
    end

endmodule

// File: tb/tb_usb_serial_in_ep_buf.sv
// Testbench for usb_serial_in_ep_buf (DEPTH=64, MAX_PKT=64, FLUSH_FRAMES=2, ZLP_EN=1).
// Stimulus pushes expected bytes and packet lengths into queues; a monitor
// compares every put byte and every done pulse against them.
module tb_usb_serial_in_ep_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       usb_reset = 1'b0;
    logic       sof_valid = 1'b0;
    logic [7:0] uart_in_data = 8'h00;
    logic       uart_in_valid = 1'b0;
    logic       uart_in_ready;
    logic       flush = 1'b0;
    logic       in_ep_req;
    logic       in_ep_grant = 1'b0;
    logic       in_ep_data_free = 1'b0;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked = 1'b0;
    logic [6:0] fifo_level;

    int n_cmp = 0;
    int n_err = 0;
    int cur_len = 0;
    logic [7:0] exp_q[$];
    int         len_q[$];

    usb_serial_in_ep_buf #(
        .DEPTH(64), .MAX_PKT(64), .FLUSH_FRAMES(2), .ZLP_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .usb_reset(usb_reset), .sof_valid(sof_valid),
        .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready), .flush(flush), .in_ep_req(in_ep_req),
        .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked), .fifo_level(fifo_level)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset || usb_reset) cur_len = 0;
        if (in_ep_data_put) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL put_unexpected: got byte 0x%0h expected no put", in_ep_data);
            end else begin
                chk("put_byte", {24'd0, in_ep_data}, {24'd0, exp_q.pop_front()});
            end
            cur_len++;
        end
        if (in_ep_data_done) begin
            if (len_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL done_unexpected: got done with %0d bytes expected none", cur_len);
            end else begin
                chk("pkt_len", cur_len, len_q.pop_front());
            end
            cur_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        logic [7:0] b;
        int k;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            uart_in_valid = 1'b1;
            uart_in_data  = b;
            exp_q.push_back(b);
            k = 0;
            while (!uart_in_ready && k < 500) begin
                tick();
                k++;
            end
            if (k >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL push_timeout: ready stayed 0 expected 1 within 500 cycles");
            end
            tick();
        end
        uart_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int cycles);
        cycles = 0;
        while (!in_ep_data_done && cycles < bound) begin
            tick();
            cycles++;
        end
        chk(name, in_ep_data_done, 1);
    endtask

    task automatic ack();
        tick();
        chk("req_in_wait_ack", in_ep_req, 0);
        in_ep_acked = 1'b1;
        tick();
        in_ep_acked = 1'b0;
    endtask

    task automatic sof_pulse();
        sof_valid = 1'b1;
        tick();
        sof_valid = 1'b0;
    endtask

    int lat;
    int puts;

    initial begin
        // Reset values
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", uart_in_ready, 1);
        chk("rst_req", in_ep_req, 0);
        chk("rst_put", in_ep_data_put, 0);
        chk("rst_done", in_ep_data_done, 0);
        chk("rst_stall", in_ep_stall, 0);

        // Full packet then ZLP
        in_ep_grant = 1'b1;
        in_ep_data_free = 1'b1;
        len_q.push_back(64);
        len_q.push_back(0);
        push_bytes(8'h00, 64);
        chk("full_level", fifo_level, 64);
        chk("full_req_not_yet", in_ep_req, 0);
        tick();
        chk("full_req_rise", in_ep_req, 1);
        wait_done("full_done", 200, lat);
        chk("full_latency", lat, 66);
        ack();
        wait_done("zlp_done", 20, lat);
        ack();
        repeat (3) tick();
        chk("zlp_idle_req", in_ep_req, 0);
        chk("zlp_idle_level", fifo_level, 0);

        // Partial packet via SOF timeout
        push_bytes(8'h40, 5);
        repeat (4) tick();
        chk("sof0_no_req", in_ep_req, 0);
        sof_pulse();
        repeat (3) tick();
        chk("sof1_no_req", in_ep_req, 0);
        len_q.push_back(5);
        sof_pulse();
        chk("sof2_req_not_yet", in_ep_req, 0);
        tick();
        chk("sof2_req", in_ep_req, 1);
        wait_done("sof_done", 50, lat);
        ack();
        repeat (4) tick();
        chk("sof_no_zlp_req", in_ep_req, 0);
        chk("sof_level", fifo_level, 0);

        // Back-pressure with no grant, then resume across pointer wrap
        in_ep_grant = 1'b0;
        push_bytes(8'h50, 64);
        chk("bp_level", fifo_level, 64);
        chk("bp_ready", uart_in_ready, 0);
        uart_in_valid = 1'b1;
        uart_in_data  = 8'h90;
        repeat (5) tick();
        chk("bp_hold_level", fifo_level, 64);
        chk("bp_hold_ready", uart_in_ready, 0);
        chk("bp_hold_req", in_ep_req, 1);
        len_q.push_back(64);
        in_ep_grant = 1'b1;
        push_bytes(8'h90, 6);
        wait_done("bp_done", 200, lat);
        ack();
        chk("bp_rest_level", fifo_level, 6);
        len_q.push_back(6);
        sof_pulse();
        sof_pulse();
        wait_done("bp_tail_done", 50, lat);
        ack();

        // Flush
        push_bytes(8'hA0, 3);
        flush = 1'b1;
        chk("flush_req_before", in_ep_req, 0);
        len_q.push_back(3);
        tick();
        flush = 1'b0;
        chk("flush_req", in_ep_req, 1);
        wait_done("flush_done", 50, lat);
        ack();
        tick();
        chk("flush_level", fifo_level, 0);

        // Bus reset mid-FILL
        in_ep_grant = 1'b0;
        push_bytes(8'hB0, 64);
        tick();
        chk("ur_req", in_ep_req, 1);
        in_ep_grant = 1'b1;
        tick();
        puts = 0;
        lat = 0;
        while (puts < 10 && lat < 100) begin
            if (in_ep_data_put) puts++;
            tick();
            lat++;
        end
        chk("ur_puts", puts, 10);
        usb_reset = 1'b1;
        tick();
        usb_reset = 1'b0;
        chk("ur_req_low", in_ep_req, 0);
        chk("ur_level", fifo_level, 54);
        chk("ur_head", in_ep_data, 8'hBA);
        repeat (3) tick();
        chk("ur_idle_req", in_ep_req, 0);
        len_q.push_back(54);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("ur_done", 200, lat);
        ack();

        // Reset during WAIT_ACK
        push_bytes(8'hF0, 4);
        len_q.push_back(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("wa_done", 50, lat);
        tick();
        chk("wa_req", in_ep_req, 0);
        push_bytes(8'hF4, 2);
        chk("wa_level", fifo_level, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("wa_rst_level", fifo_level, 0);
        chk("wa_rst_ready", uart_in_ready, 1);
        chk("wa_rst_req", in_ep_req, 0);
        chk("wa_rst_put", in_ep_data_put, 0);
        chk("wa_rst_done", in_ep_data_done, 0);
        chk("wa_rst_stall", in_ep_stall, 0);
        push_bytes(8'h11, 1);
        len_q.push_back(1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("post_rst_done", 50, lat);
        ack();
        repeat (3) tick();

        chk("exp_bytes_left", exp_q.size(), 0);
        chk("exp_pkts_left", len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
